// File: rtl/anti_theft_core_n.sv
// Parametrised anti-theft controller: arming/alarm FSM, time bank, seconds tick and countdown.
// Define ANTI_THEFT_SIREN_PULSE_EN to make the siren chirp on each tick while the alarm sounds.
module anti_theft_core_n #(
  parameter int NUM_DOORS       = 2,
  parameter int TIME_W          = 4,
  parameter int TICKS_PER_SEC   = 25000000,
  parameter int DEF_T_ARM       = 6,
  parameter int DEF_T_DRIVER    = 8,
  parameter int DEF_T_PASSENGER = 15,
  parameter int DEF_T_ALARM     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ignition,
  input  logic [NUM_DOORS-1:0] doors,
  input  logic                 reprogram,
  input  logic [1:0]           param_sel,
  input  logic [TIME_W-1:0]    param_value,
  output logic                 siren,
  output logic                 status_led,
  output logic [2:0]           state_out,
  output logic [TIME_W-1:0]    count_out,
  output logic [NUM_DOORS-1:0] door_latched
);

  localparam int TICK_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_ARMED       = 3'd0,
    S_TRIGGERED   = 3'd1,
    S_SOUND_ALARM = 3'd2,
    S_DISARMED    = 3'd3,
    S_WAIT_OPEN   = 3'd4,
    S_WAIT_CLOSE  = 3'd5,
    S_ARM_DELAY   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic                  rp_q, rp_edge;
  logic [TIME_W-1:0]     bank_q [4];
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  tick;
  logic [TIME_W-1:0]     cnt_q, cnt_d;
  logic                  run_q, run_d, expired;
  logic                  start, stop, latch_en;
  logic [TIME_W-1:0]     load_val;
  logic [NUM_DOORS-1:0]  latch_q;
  logic                  led_q, led_d, siren_q, siren_d;
  logic                  any_door;

  assign rp_edge  = reprogram & ~rp_q;
  assign any_door = |doors;
  assign tick     = (tick_cnt_q == TICK_LAST);
  assign expired  = run_q & (cnt_q == '0);

  // Time-parameter bank: written once per rising edge of reprogram
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q      <= 1'b0;
      bank_q[0] <= TIME_W'(DEF_T_ARM);
      bank_q[1] <= TIME_W'(DEF_T_DRIVER);
      bank_q[2] <= TIME_W'(DEF_T_PASSENGER);
      bank_q[3] <= TIME_W'(DEF_T_ALARM);
    end else begin
      rp_q <= reprogram;
      if (rp_edge) bank_q[param_sel] <= param_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_ARMED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    stop     = 1'b0;
    latch_en = 1'b0;
    load_val = '0;
    if (rp_edge) begin
      state_d = S_ARMED;
      stop    = 1'b1;
    end else if (ignition) begin
      state_d = S_DISARMED;
      stop    = 1'b1;
    end else begin
      case (state_q)
        S_ARMED: if (any_door) begin
          state_d  = S_TRIGGERED;
          latch_en = 1'b1;
          start    = 1'b1;
          load_val = doors[0] ? bank_q[1] : bank_q[2];
        end
        S_TRIGGERED: if (expired) begin
          state_d  = S_SOUND_ALARM;
          start    = 1'b1;
          load_val = bank_q[3];
        end
        // An open door keeps the alarm time topped up until every door closes
        S_SOUND_ALARM: begin
          if (any_door) begin
            start    = 1'b1;
            load_val = bank_q[3];
          end else if (expired) begin
            state_d = S_ARMED;
          end
        end
        S_DISARMED:  state_d = S_WAIT_OPEN;
        S_WAIT_OPEN: if (any_door) state_d = S_WAIT_CLOSE;
        S_WAIT_CLOSE: if (!any_door) begin
          state_d  = S_ARM_DELAY;
          start    = 1'b1;
          load_val = bank_q[0];
        end
        S_ARM_DELAY: begin
          if (any_door) begin
            state_d = S_WAIT_CLOSE;
            stop    = 1'b1;
          end else if (expired) begin
            state_d = S_ARMED;
          end
        end
        default: state_d = S_ARMED;
      endcase
    end
  end

  // Countdown and tick divider; a start realigns the divider so the first second is full length
  always_comb begin
    cnt_d      = cnt_q;
    run_d      = run_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    if (stop) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (start) begin
      cnt_d      = load_val;
      run_d      = 1'b1;
      tick_cnt_d = '0;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else if (tick)   cnt_d = cnt_q - TIME_W'(1);
    end
  end

  always_comb begin
    led_d   = 1'b0;
    siren_d = 1'b0;
    case (state_d)
      S_ARMED:     led_d = (state_q != S_ARMED) ? 1'b0 : (tick ? ~led_q : led_q);
      S_TRIGGERED: led_d = 1'b1;
      S_SOUND_ALARM: begin
        led_d = 1'b1;
`ifdef ANTI_THEFT_SIREN_PULSE_EN
        siren_d = (state_q != S_SOUND_ALARM) ? 1'b1 : (tick ? ~siren_q : siren_q);
`else
        siren_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      latch_q    <= '0;
      led_q      <= 1'b0;
      siren_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      led_q      <= led_d;
      siren_q    <= siren_d;
      if (latch_en) latch_q <= doors;
    end
  end

  assign state_out    = state_q;
  assign count_out    = cnt_q;
  assign siren        = siren_q;
  assign status_led   = led_q;
  assign door_latched = latch_q;

endmodule

// File: tb/tb_anti_theft_core_n.sv
// Bench for anti_theft_core_n: directed scenarios plus randomized traffic against a cycle model.
module tb_anti_theft_core_n;
  localparam int TPS = 4;
  localparam int ND  = 3;
  localparam int TW  = 4;
`ifdef ANTI_THEFT_SIREN_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ignition = 1'b0;
  logic [ND-1:0] doors = '0;
  logic          reprogram = 1'b0;
  logic [1:0]    param_sel = '0;
  logic [TW-1:0] param_value = '0;
  logic          siren, status_led;
  logic [2:0]    state_out;
  logic [TW-1:0] count_out;
  logic [ND-1:0] door_latched;

  int n_cmp = 0;
  int n_err = 0;

  anti_theft_core_n #(
    .NUM_DOORS(ND), .TIME_W(TW), .TICKS_PER_SEC(TPS)
  ) dut (
    .clk(clk), .rst(rst), .ignition(ignition), .doors(doors),
    .reprogram(reprogram), .param_sel(param_sel), .param_value(param_value),
    .siren(siren), .status_led(status_led), .state_out(state_out),
    .count_out(count_out), .door_latched(door_latched)
  );

  always #5 clk = ~clk;

  // Reference model: state number, seconds left, cycles into the current second
  int      m_state, m_left, m_sub;
  int      m_bank [4];
  bit      m_run, m_led, m_siren, m_prev_rp;
  bit [ND-1:0] m_latch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit tick, expd, go, halt;
    int ns, load;
    if (rst) begin
      m_state = 0; m_left = 0; m_run = 0; m_sub = 0;
      m_led = 0; m_siren = 0; m_latch = '0; m_prev_rp = 0;
      m_bank[0] = 6; m_bank[1] = 8; m_bank[2] = 15; m_bank[3] = 10;
      return;
    end
    tick = (m_sub == TPS - 1);
    expd = m_run && (m_left == 0);
    go = 0; halt = 0; load = 0; ns = m_state;
    if (reprogram && !m_prev_rp) begin
      m_bank[param_sel] = int'(param_value);
      ns = 0; halt = 1;
    end else if (ignition) begin
      ns = 3; halt = 1;
    end else begin
      case (m_state)
        0: if (doors != 0) begin
             ns = 1; m_latch = doors; go = 1;
             load = ((doors & 1) != 0) ? m_bank[1] : m_bank[2];
           end
        1: if (expd) begin ns = 2; go = 1; load = m_bank[3]; end
        2: if (doors != 0) begin go = 1; load = m_bank[3]; end
           else if (expd) ns = 0;
        3: ns = 4;
        4: if (doors != 0) ns = 5;
        5: if (doors == 0) begin ns = 6; go = 1; load = m_bank[0]; end
        6: if (doors != 0) begin ns = 5; halt = 1; end
           else if (expd) ns = 0;
        default: ns = 0;
      endcase
    end
    if (halt) begin m_run = 0; m_left = 0; end
    else if (go) begin m_run = 1; m_left = load; end
    else if (m_run) begin
      if (m_left == 0) m_run = 0;
      else if (tick) m_left--;
    end
    if (go) m_sub = 0;
    else m_sub = tick ? 0 : m_sub + 1;
    if (ns == 0) m_led = (m_state != 0) ? 1'b0 : (tick ? !m_led : m_led);
    else m_led = (ns == 1 || ns == 2);
    if (ns != 2) m_siren = 0;
    else if (!PULSE || m_state != 2) m_siren = 1;
    else if (tick) m_siren = !m_siren;
    m_prev_rp = reprogram;
    m_state = ns;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_state", state_out, m_state);
    chk("model_count", count_out, m_left);
    chk("model_siren", siren, m_siren);
    chk("model_led", status_led, m_led);
    chk("model_latched", door_latched, m_latch);
  endtask

  initial begin
    int n;
    // Reset
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_state", state_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_siren", siren, 0);
    chk("rst_led", status_led, 0);
    chk("rst_latched", door_latched, 0);
    rst = 1'b0;
    cyc(); cyc();

    // Passenger door trigger, then alarm
    doors = 3'b100;
    cyc();
    chk("trig_state", state_out, 1);
    chk("trig_count", count_out, 15);
    chk("trig_latched", door_latched, 3'b100);
    doors = '0;
    n = 0;
    while (state_out != 3'd2 && n < 100) begin cyc(); n++; end
    chk("trig_to_alarm_cycles", n, 61);
    chk("alarm_siren", siren, 1);
    chk("alarm_count", count_out, 10);

    // Door held open during alarm keeps reloading
    doors = 3'b010;
    for (int i = 0; i < 80; i++) begin
      cyc();
      chk("alarm_hold_count", count_out, 10);
    end
    doors = '0;
    for (int k = 1; k <= 41; k++) begin
      cyc();
      if (k <= 40) begin
        chk("alarm_run_state", state_out, 2);
        chk("alarm_siren_pattern", siren, PULSE ? (((k / 4) % 2) == 0) : 1);
      end
    end
    chk("rearm_state", state_out, 0);
    chk("rearm_siren", siren, 0);
    chk("rearm_led", status_led, 0);
    n = 0;
    while (!status_led && n < 10) begin cyc(); n++; end
    chk("led_first_toggle", n, 3);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("led_blink", status_led, ((i / 4) % 2) == 0);
    end

    // Driver + passenger together use the driver delay; ignition disarms
    doors = 3'b011;
    cyc();
    chk("both_state", state_out, 1);
    chk("both_count", count_out, 8);
    chk("both_latched", door_latched, 3'b011);
    doors = 3'b100;
    cyc();
    doors = '0;
    chk("latched_kept", door_latched, 3'b011);
    n = 0;
    while (count_out != 4'd5 && n < 40) begin cyc(); n++; end
    chk("reach_count5", count_out, 5);
    ignition = 1'b1;
    cyc();
    chk("disarm_state", state_out, 3);
    chk("disarm_count", count_out, 0);
    chk("disarm_siren", siren, 0);
    chk("disarm_led", status_led, 0);

    // Leave the car: arm delay, interrupted and restarted
    ignition = 1'b0;
    cyc();
    chk("wait_open", state_out, 4);
    doors = 3'b001;
    cyc();
    chk("wait_close", state_out, 5);
    doors = '0;
    cyc();
    chk("arm_delay_state", state_out, 6);
    chk("arm_delay_count", count_out, 6);
    n = 0;
    while (count_out != 4'd3 && n < 40) begin cyc(); n++; end
    chk("arm_delay_at3", count_out, 3);
    doors = 3'b001;
    cyc();
    chk("reopen_state", state_out, 5);
    chk("reopen_count", count_out, 0);
    doors = '0;
    cyc();
    chk("reload_count", count_out, 6);
    n = 0;
    while (state_out != 3'd0 && n < 60) begin cyc(); n++; end
    chk("arm_delay_cycles", n, 25);

    // Reprogram driver delay to 0 while triggered; a held button writes once
    doors = 3'b100;
    cyc();
    doors = '0;
    cyc(); cyc(); cyc();
    reprogram = 1'b1; param_sel = 2'd1; param_value = 4'd0;
    cyc();
    chk("reprog_state", state_out, 0);
    chk("reprog_count", count_out, 0);
    chk("reprog_siren", siren, 0);
    param_value = 4'd9;
    for (int i = 0; i < 9; i++) cyc();
    reprogram = 1'b0;
    cyc();
    doors = 3'b001;
    cyc();
    chk("zero_load_state", state_out, 1);
    chk("zero_load_count", count_out, 0);
    doors = '0;
    cyc();
    chk("zero_expiry_state", state_out, 2);
    chk("zero_expiry_count", count_out, 10);
    chk("zero_expiry_siren", siren, 1);
    ignition = 1'b1;
    cyc();
    chk("alarm_disarm", state_out, 3);
    chk("alarm_disarm_siren", siren, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (ignition) ignition = ($urandom_range(0, 9) != 0);
      else          ignition = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0)
        doors = ($urandom_range(0, 2) == 0) ? ND'($urandom) : '0;
      if ($urandom_range(0, 59) == 0) reprogram = ~reprogram;
      param_sel   = 2'($urandom);
      param_value = TW'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
